// File: rtl/regcsr_pkg.sv
// Shared constants for the integer register file and machine-mode CSR bank.
// Holds CSR addresses, the csr_op encoding, the misa value, mstatus bit positions and write masks.
package regcsr_pkg;

   localparam int unsigned REG_AW  = 5;
   localparam int unsigned CSR_AW  = 12;
   localparam int unsigned CNT_W   = 64;
   localparam int unsigned HALF_W  = 32;

   typedef enum logic [1:0] {
      CSR_NONE  = 2'b00,
      CSR_WRITE = 2'b01,
      CSR_SET   = 2'b10,
      CSR_CLEAR = 2'b11
   } csr_op_e;

   localparam logic [CSR_AW-1:0] CSR_MSTATUS   = 12'h300;
   localparam logic [CSR_AW-1:0] CSR_MISA      = 12'h301;
   localparam logic [CSR_AW-1:0] CSR_MTVEC     = 12'h305;
   localparam logic [CSR_AW-1:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [CSR_AW-1:0] CSR_MEPC      = 12'h341;
   localparam logic [CSR_AW-1:0] CSR_MCAUSE    = 12'h342;
   localparam logic [CSR_AW-1:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [CSR_AW-1:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [CSR_AW-1:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [CSR_AW-1:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [CSR_AW-1:0] CSR_MVENDORID = 12'hF11;

   localparam logic [31:0] MISA_VAL = 32'h4000_0100;

   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MSTATUS_MPP_HI = 12;

   localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
   localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half takes priority over the increment in that cycle.
module csr_counter64
   import regcsr_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_i,
   input  logic              lo_we_i,
   input  logic              hi_we_i,
   input  logic [HALF_W-1:0] wdata_i,
   output logic [CNT_W-1:0]  value_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin : cnt_next
      cnt_d = cnt_q;
      if (lo_we_i || hi_we_i) begin
         if (lo_we_i) cnt_d[HALF_W-1:0]     = wdata_i;
         if (hi_we_i) cnt_d[CNT_W-1:HALF_W] = wdata_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign value_o = cnt_q;

endmodule

// File: rtl/regcsr_bank.sv
// GPR file with same-cycle write bypass plus the machine-mode CSR bank
// (atomic CSRRW/CSRRS/CSRRC port, 64-bit cycle/instret counters, trap entry and mret).
module regcsr_bank
   import regcsr_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     NREG      = 32,
   parameter int unsigned     NRD       = 2,
   parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*REG_AW-1:0] rs_raddr,
   output logic [NRD*XLEN-1:0]   rs_rdata,
   input  logic                  rd_we,
   input  logic [REG_AW-1:0]     rd_waddr,
   input  logic [XLEN-1:0]       rd_wdata,
   input  logic [1:0]            csr_op,
   input  logic [CSR_AW-1:0]     csr_addr,
   input  logic [XLEN-1:0]       csr_src,
   output logic [XLEN-1:0]       csr_rdata,
   output logic                  csr_illegal,
   input  logic                  retire,
   input  logic                  trap_valid,
   input  logic [XLEN-1:0]       trap_pc,
   input  logic [XLEN-1:0]       trap_cause,
   input  logic                  mret,
   output logic [XLEN-1:0]       mtvec_o,
   output logic [XLEN-1:0]       mepc_o,
   output logic                  mie_o
);

   localparam logic [XLEN-1:0] ALIGN = XLEN'(ALIGN4_MASK);

   logic [XLEN-1:0] gpr_q [NREG];

   // GPR write port; x0 is never written so it always reads back zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) gpr_q[i] <= '0;
      end else if (rd_we && (rd_waddr != '0)) begin
         gpr_q[rd_waddr] <= rd_wdata;
      end
   end

   for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
      assign addr = rs_raddr[i*REG_AW +: REG_AW];
      always_comb begin
         data = gpr_q[addr];
         if (addr == '0)                       data = '0;
         else if (rd_we && (addr == rd_waddr)) data = rd_wdata;
      end
      assign rs_rdata[i*XLEN +: XLEN] = data;
   end

   logic            mie_q, mie_d, mpie_q, mpie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
   logic [XLEN-1:0] mstatus_rd, csr_old, csr_new;
   logic [CNT_W-1:0] mcycle, minstret;
   logic            csr_impl, csr_ro, csr_act, csr_wr_intent, csr_we;
   csr_op_e         op;

   assign op = csr_op_e'(csr_op);

   always_comb begin : mstatus_view
      mstatus_rd = '0;
      mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mstatus_rd[MSTATUS_MPIE] = mpie_q;
      mstatus_rd[MSTATUS_MIE]  = mie_q;
   end

   always_comb begin : csr_decode
      csr_impl = 1'b1;
      csr_ro   = 1'b0;
      csr_old  = '0;
      case (csr_addr)
         CSR_MSTATUS:   csr_old = mstatus_rd;
         CSR_MISA:      begin csr_old = XLEN'(MISA_VAL); csr_ro = 1'b1; end
         CSR_MTVEC:     csr_old = mtvec_q;
         CSR_MSCRATCH:  csr_old = mscratch_q;
         CSR_MEPC:      csr_old = mepc_q;
         CSR_MCAUSE:    csr_old = mcause_q;
         CSR_MCYCLE:    csr_old = XLEN'(mcycle[HALF_W-1:0]);
         CSR_MCYCLEH:   csr_old = XLEN'(mcycle[CNT_W-1:HALF_W]);
         CSR_MINSTRET:  csr_old = XLEN'(minstret[HALF_W-1:0]);
         CSR_MINSTRETH: csr_old = XLEN'(minstret[CNT_W-1:HALF_W]);
         CSR_MVENDORID: csr_ro = 1'b1;
         default:       csr_impl = 1'b0;
      endcase
   end

   always_comb begin : csr_modify
      csr_new = csr_old;
      case (op)
         CSR_WRITE: csr_new = csr_src;
         CSR_SET:   csr_new = csr_old | csr_src;
         CSR_CLEAR: csr_new = csr_old & ~csr_src;
         default:   csr_new = csr_old;
      endcase
   end

   // set/clear with a zero operand is a pure read and is allowed on read-only CSRs
   assign csr_act       = (op != CSR_NONE);
   assign csr_wr_intent = (op == CSR_WRITE) || (csr_src != '0);
   assign csr_illegal   = csr_act && (!csr_impl || (csr_ro && csr_wr_intent));
   assign csr_rdata     = (csr_act && !csr_illegal) ? csr_old : '0;
   assign csr_we        = csr_act && !csr_illegal && csr_wr_intent && !trap_valid && !mret;

   always_comb begin : csr_next
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      if (trap_valid) begin
         mepc_d   = trap_pc & ALIGN;
         mcause_d = trap_cause;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (csr_we) begin
         case (csr_addr)
            CSR_MSTATUS:  begin mie_d = csr_new[MSTATUS_MIE]; mpie_d = csr_new[MSTATUS_MPIE]; end
            CSR_MTVEC:    mtvec_d    = csr_new & ALIGN;
            CSR_MSCRATCH: mscratch_d = csr_new;
            CSR_MEPC:     mepc_d     = csr_new & ALIGN;
            CSR_MCAUSE:   mcause_d   = csr_new;
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RST & ALIGN;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
      end
   end

   csr_counter64 u_mcycle (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (1'b1),
      .lo_we_i (csr_we && (csr_addr == CSR_MCYCLE)),
      .hi_we_i (csr_we && (csr_addr == CSR_MCYCLEH)),
      .wdata_i (HALF_W'(csr_new)),
      .value_o (mcycle)
   );

   csr_counter64 u_minstret (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (retire),
      .lo_we_i (csr_we && (csr_addr == CSR_MINSTRET)),
      .hi_we_i (csr_we && (csr_addr == CSR_MINSTRETH)),
      .wdata_i (HALF_W'(csr_new)),
      .value_o (minstret)
   );

   assign mtvec_o = mtvec_q;
   assign mepc_o  = mepc_q;
   assign mie_o   = mie_q;

endmodule

// File: tb/tb_regcsr_bank.sv
// Directed and randomized bench for regcsr_bank against a behavioural register/CSR model.
module tb_regcsr_bank;

   localparam logic [31:0] MTV_RST = 32'h0000_0080;

   logic        clk, rst;
   logic [9:0]  rs_raddr;
   logic [63:0] rs_rdata;
   logic        rd_we;
   logic [4:0]  rd_waddr;
   logic [31:0] rd_wdata;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_src, csr_rdata;
   logic        csr_illegal, retire, trap_valid, mret, mie_o;
   logic [31:0] trap_pc, trap_cause, mtvec_o, mepc_o;

   regcsr_bank #(.XLEN(32), .NREG(32), .NRD(2), .MTVEC_RST(MTV_RST)) dut (
      .clk(clk), .rst(rst), .rs_raddr(rs_raddr), .rs_rdata(rs_rdata),
      .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
      .csr_op(csr_op), .csr_addr(csr_addr), .csr_src(csr_src),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .retire(retire), .trap_valid(trap_valid), .trap_pc(trap_pc),
      .trap_cause(trap_cause), .mret(mret),
      .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // behavioural architectural state
   logic [31:0] m_gpr [32];
   bit          m_mie, m_mpie;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
   logic [63:0] m_mcycle, m_minstret;

   logic [11:0] addrs [14];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_mie = 0; m_mpie = 0;
      m_mtvec = MTV_RST & 32'hFFFF_FFFC;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_mcycle = 0; m_minstret = 0;
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a, output bit impl, output bit ro);
      logic [31:0] v;
      impl = 1; ro = 0; v = 0;
      case (a)
         12'h300: v = 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         12'h301: begin v = 32'h4000_0100; ro = 1; end
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'hB00: v = m_mcycle[31:0];
         12'hB80: v = m_mcycle[63:32];
         12'hB02: v = m_minstret[31:0];
         12'hB82: v = m_minstret[63:32];
         12'hF11: begin v = 0; ro = 1; end
         default: impl = 0;
      endcase
      return v;
   endfunction

   task automatic idle();
      rst = 0; rs_raddr = 0; rd_we = 0; rd_waddr = 0; rd_wdata = 0;
      csr_op = 0; csr_addr = 0; csr_src = 0; retire = 0;
      trap_valid = 0; trap_pc = 0; trap_cause = 0; mret = 0;
   endtask

   task automatic begin_step();
      @(negedge clk);
      idle();
   endtask

   // check every output against the model, then advance the model across the posedge
   task automatic tick();
      logic [4:0]  a;
      logic [31:0] exp_rs, old, nv;
      bit          impl, ro, wr, ill, cyc_w, ins_w;
      #1;
      for (int p = 0; p < 2; p++) begin
         a = rs_raddr[5*p +: 5];
         if (a == 0) exp_rs = 0;
         else if (rd_we && a == rd_waddr) exp_rs = rd_wdata;
         else exp_rs = m_gpr[a];
         check($sformatf("rs_rdata%0d", p), rs_rdata[32*p +: 32], exp_rs);
      end
      old = m_read(csr_addr, impl, ro);
      wr  = (csr_op == 2'b01) || (csr_src != 0);
      ill = (csr_op != 2'b00) && (!impl || (ro && wr));
      check("csr_rdata", csr_rdata, (csr_op != 2'b00 && !ill) ? old : 32'h0);
      check("csr_illegal", 32'(csr_illegal), 32'(ill));
      check("mtvec_o", mtvec_o, m_mtvec);
      check("mepc_o", mepc_o, m_mepc);
      check("mie_o", 32'(mie_o), 32'(m_mie));
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         cyc_w = 0; ins_w = 0;
         if (rd_we && rd_waddr != 0) m_gpr[rd_waddr] = rd_wdata;
         case (csr_op)
            2'b01:   nv = csr_src;
            2'b10:   nv = old | csr_src;
            default: nv = old & ~csr_src;
         endcase
         if (csr_op != 2'b00 && !ill && wr && !trap_valid && !mret) begin
            case (csr_addr)
               12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
               12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
               12'h340: m_mscratch = nv;
               12'h341: m_mepc = nv & 32'hFFFF_FFFC;
               12'h342: m_mcause = nv;
               12'hB00: begin m_mcycle[31:0] = nv; cyc_w = 1; end
               12'hB80: begin m_mcycle[63:32] = nv; cyc_w = 1; end
               12'hB02: begin m_minstret[31:0] = nv; ins_w = 1; end
               12'hB82: begin m_minstret[63:32] = nv; ins_w = 1; end
               default: ;
            endcase
         end
         if (trap_valid) begin
            m_mepc = trap_pc & 32'hFFFF_FFFC; m_mcause = trap_cause;
            m_mpie = m_mie; m_mie = 0;
         end else if (mret) begin
            m_mie = m_mpie; m_mpie = 1;
         end
         if (!cyc_w) m_mcycle = m_mcycle + 64'd1;
         if (retire && !ins_w) m_minstret = m_minstret + 64'd1;
      end
   endtask

   task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s);
      begin_step();
      csr_op = op; csr_addr = a; csr_src = s;
   endtask

   task automatic csr_expect(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csr_do(2'b10, a, 32'h0);
      #1 check(tag, csr_rdata, exp);
      tick();
   endtask

   initial begin
      addrs = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'h7C0, 12'h344, 12'hC00};
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      check("rst_mtvec_o", mtvec_o, MTV_RST);
      check("rst_mepc_o", mepc_o, 32'h0);
      check("rst_mie_o", 32'(mie_o), 32'h0);
      csr_expect("mcycle_first", 12'hB00, 32'd0);
      csr_expect("mcycle_second", 12'hB00, 32'd1);
      csr_expect("mstatus_rst", 12'h300, 32'h0000_1800);

      // GPR bypass and x0
      begin_step(); rd_we = 1; rd_waddr = 5; rd_wdata = 32'hDEAD_BEEF; rs_raddr = {5'd5, 5'd5};
      #1 check("bypass_p0", rs_rdata[31:0], 32'hDEAD_BEEF);
      check("bypass_p1", rs_rdata[63:32], 32'hDEAD_BEEF);
      tick();
      begin_step(); rs_raddr = {5'd5, 5'd5};
      #1 check("x5_stored", rs_rdata[63:32], 32'hDEAD_BEEF);
      tick();
      begin_step(); rd_we = 1; rd_waddr = 0; rd_wdata = 32'h1; rs_raddr = {5'd0, 5'd0};
      #1 check("x0_bypass", rs_rdata[31:0], 32'h0);
      tick();
      begin_step(); rs_raddr = {5'd0, 5'd0};
      #1 check("x0_after", rs_rdata[63:32], 32'h0);
      tick();

      // mscratch set/clear
      csr_do(2'b01, 12'h340, 32'h0000_F0F0); tick();
      csr_do(2'b10, 12'h340, 32'h0000_000F);
      #1 check("set_old", csr_rdata, 32'h0000_F0F0);
      tick();
      csr_expect("after_set", 12'h340, 32'h0000_F0FF);
      csr_do(2'b11, 12'h340, 32'h0000_00F0); tick();
      csr_expect("after_clear", 12'h340, 32'h0000_F00F);

      // mstatus, trap entry, mret
      csr_do(2'b01, 12'h300, 32'hFFFF_FFFF); tick();
      #1 check("mie_set", 32'(mie_o), 32'h1);
      csr_expect("mstatus_ones", 12'h300, 32'h0000_1888);
      begin_step(); trap_valid = 1; trap_pc = 32'h100; trap_cause = 32'hB; tick();
      csr_expect("trap_mepc", 12'h341, 32'h100);
      csr_expect("trap_mcause", 12'h342, 32'hB);
      csr_expect("trap_mstatus", 12'h300, 32'h0000_1880);
      begin_step(); mret = 1; tick();
      csr_expect("mret_mstatus", 12'h300, 32'h0000_1888);

      // read-only and unimplemented CSRs
      csr_do(2'b01, 12'h301, 32'h1234);
      #1 check("misa_wr_illegal", 32'(csr_illegal), 32'h1);
      tick();
      csr_expect("misa_read", 12'h301, 32'h4000_0100);
      csr_do(2'b01, 12'h7C0, 32'h5);
      #1 check("unimpl_illegal", 32'(csr_illegal), 32'h1);
      check("unimpl_rdata", csr_rdata, 32'h0);
      tick();

      // counter carry and minstret
      csr_do(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
      csr_do(2'b01, 12'hB80, 32'h0); tick();
      csr_expect("mcycle_lo_hold", 12'hB00, 32'hFFFF_FFFF);
      csr_expect("mcycleh_carry", 12'hB80, 32'h1);
      repeat (3) begin begin_step(); retire = 1; tick(); end
      csr_expect("minstret_3", 12'hB02, 32'd3);
      csr_do(2'b01, 12'hB02, 32'hFFFF_FFFF); retire = 1; tick();
      csr_do(2'b01, 12'hB82, 32'hFFFF_FFFF); retire = 1; tick();
      begin_step(); retire = 1; tick();
      csr_expect("minstret_wrap_lo", 12'hB02, 32'h0);
      csr_expect("minstret_wrap_hi", 12'hB82, 32'h0);

      // trap beats a same-cycle CSR write
      csr_do(2'b01, 12'h341, 32'h444); trap_valid = 1; trap_pc = 32'h200; trap_cause = 32'h2; tick();
      csr_expect("trap_over_csr", 12'h341, 32'h200);
      csr_do(2'b01, 12'h305, 32'h0000_1003); tick();
      #1 check("mtvec_align", mtvec_o, 32'h0000_1000);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         begin_step();
         rs_raddr   = 10'($urandom);
         rd_we      = 1'($urandom);
         rd_waddr   = 5'($urandom);
         rd_wdata   = $urandom;
         if ($urandom_range(3) == 0) rs_raddr[4:0] = rd_waddr;
         csr_op     = 2'($urandom);
         csr_addr   = addrs[$urandom_range(13)];
         csr_src    = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
         retire     = 1'($urandom);
         trap_valid = ($urandom_range(15) == 0);
         mret       = ($urandom_range(7) == 0);
         trap_pc    = $urandom;
         trap_cause = $urandom;
         tick();
      end

      // reset wins over simultaneous activity
      csr_do(2'b01, 12'h305, 32'h0000_4000);
      rst = 1; rd_we = 1; rd_waddr = 5; rd_wdata = 32'h1234_5678;
      trap_valid = 1; trap_pc = 32'h300; retire = 1;
      tick();
      #1 check("mid_rst_mtvec", mtvec_o, MTV_RST);
      check("mid_rst_mepc", mepc_o, 32'h0);
      check("mid_rst_mie", 32'(mie_o), 32'h0);
      csr_do(2'b10, 12'hB00, 32'h0); rs_raddr = {5'd5, 5'd5};
      #1 check("mid_rst_mcycle", csr_rdata, 32'h0);
      check("mid_rst_x5", rs_rdata[31:0], 32'h0);
      tick();
      csr_expect("mid_rst_minstret", 12'hB02, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/regcsr_bank.md
# regcsr_bank

Parametrised integer register file plus machine-mode CSR bank for the single-issue core: N combinational read ports with same-cycle write bypass, one GPR write port, and an atomic CSR read-modify-write port. It adds CSRRW/CSRRS/CSRRC semantics, 64-bit mcycle/minstret counters, trap entry/mret handling of mstatus/mepc/mcause, and illegal-access flagging. It sits between decode (addresses) and execute/writeback (data, ops, retire, trap).

## Interface
- XLEN, 32, data width (32 only for RV32 misa; counters always 64-bit)
- NREG, 32, GPR count; x0 hardwired zero
- NRD, 2, GPR read port count
- MTVEC_RST, 0, mtvec reset value
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- rs_raddr  in  NRD*5  packed read addresses, port i at [5i+4:5i]
- rs_rdata  out  NRD*XLEN  packed read data
- rd_we  in  1  GPR write enable
- rd_waddr  in  5  GPR write address
- rd_wdata  in  XLEN  GPR write data
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear
- csr_addr  in  12  CSR address
- csr_src  in  XLEN  operand (rs1 value or zimm)
- csr_rdata  out  XLEN  pre-modification CSR value
- csr_illegal  out  1  access to unimplemented or read-only CSR write
- retire  in  1  one instruction retired this cycle
- trap_valid  in  1  take trap this cycle
- trap_pc, trap_cause  in  XLEN  pc and cause for trap entry
- mret  in  1  return from trap this cycle
- mtvec_o, mepc_o  out  XLEN  registered CSR values for fetch redirect
- mie_o  out  1  mstatus.MIE

## Operation
- GPR read: address 0 -> 0; address == rd_waddr with rd_we -> rd_wdata; else stored value. Write at posedge if rd_we and rd_waddr != 0.
- Implemented CSRs: mstatus 0x300, misa 0x301 (RO), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82, mvendorid 0xF11 (RO, 0).
- csr_rdata = current value (combinational, no CSR bypass; writes take effect next cycle). Zero when op none or illegal.
- New value: write -> src; set -> old|src; clear -> old&~src.
- Set/clear with csr_src == 0 perform no write and are legal on RO CSRs.
- csr_illegal = op != none and (address unimplemented, or write to RO CSR). Illegal -> no state change.
- mstatus: only MIE (bit 3) and MPIE (bit 7) writable; MPP [12:11] reads 2'b11; other bits read 0.
- mtvec/mepc bits [1:0] read and write as 0.
- misa reads 0x40000100.
- mcycle increments every non-reset cycle; minstret increments when retire. A CSR write to either half replaces that half and suppresses that counter's increment that cycle. Wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
- Trap entry: mepc <= trap_pc, mcause <= trap_cause, MPIE <= MIE, MIE <= 0.
- mret: MIE <= MPIE, MPIE <= 1.
- Priority same cycle: trap_valid > mret > CSR write. A suppressed CSR write still reports csr_rdata/csr_illegal. Counters count regardless.

## Timing
- All reads combinational; all state updates at posedge clk.
- Reset: all GPRs 0, mstatus 0 (reads 0x1800), mtvec MTVEC_RST, mscratch/mepc/mcause 0, counters 0.
- Reset outputs: mtvec_o = MTVEC_RST, mepc_o = 0, mie_o = 0.
- Reset wins over every simultaneous write, trap or increment. The first cycle after reset reads mcycle = 0; the next reads 1.
- No handshake. Callers assert each input for exactly one cycle per event.

## Structure
- Package regcsr_pkg: CSR address constants, csr_op encoding, MISA_VAL, mstatus bit indices, write masks.
- Sub-module csr_counter64, instantiated twice (mcycle, minstret): inc, lo_we, hi_we, wdata; 64-bit value out.

## Test plan
- Write x5 = 0xDEADBEEF while reading x5 on ports 0/1 -> both show 0xDEADBEEF same cycle and the next. Write x0 = 1 -> x0 reads 0.
- mscratch = 0xF0F0: set 0x000F -> csr_rdata 0xF0F0, then reads 0xF0FF. Clear 0x00F0 -> reads 0xF00F.
- mstatus write 0xFFFFFFFF -> reads 0x1888. trap_valid, pc 0x100, cause 0xB -> mepc 0x100, mcause 0xB, mstatus 0x1880. mret -> 0x1888.
- Write misa -> csr_illegal = 1, value unchanged. Set misa with src 0 -> legal, rdata 0x40000100. Access 0x7C0 -> illegal, rdata 0.
- Write mcycle = 0xFFFFFFFF, mcycleh = 0 -> next cycle low 0xFFFFFFFF, then mcycleh 1 and low 0 (carry). retire for 3 cycles -> minstret 3.
- Trap and CSR write to mepc in the same cycle -> mepc = trap_pc. rst asserted mid-sequence -> all state at reset values next cycle.
